// File: rtl/seg7_capture.sv
// Captures an active-low 7-segment bus, filters glitches, decodes the glyph
// and flags +1 / -1 / jump transitions between successive valid digits.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       hex_in,
    output logic [3:0]       value,
    output logic             valid,
    output logic             invalid,
    output logic             step_up,
    output logic             step_down,
    output logic             jump,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [6:0] BLANK    = 7'h7F;
    localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] acc;
    logic [7:0] run;
    logic       glyph_ok;
    logic [3:0] glyph_val;
    logic [3:0] val_inc;
    logic [3:0] val_dec;
    logic       accept;

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (s2)
            7'h40: glyph_val = 4'h0;
            7'h79: glyph_val = 4'h1;
            7'h24: glyph_val = 4'h2;
            7'h30: glyph_val = 4'h3;
            7'h19: glyph_val = 4'h4;
            7'h12: glyph_val = 4'h5;
            7'h02: glyph_val = 4'h6;
            7'h78: glyph_val = 4'h7;
            7'h00: glyph_val = 4'h8;
            7'h18: glyph_val = 4'h9;
            7'h08: glyph_val = 4'hA;
            7'h03: glyph_val = 4'hB;
            7'h46: glyph_val = 4'hC;
            7'h21: glyph_val = 4'hD;
            7'h06: glyph_val = 4'hE;
            7'h0E: glyph_val = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // run holds (edges since s2 last changed); s2 has then held for run+1 cycles
    assign val_inc = value + 4'd1;
    assign val_dec = value - 4'd1;
    assign accept  = (run == RUN_LAST) && (s2 != acc);

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1         <= BLANK;
            s2         <= BLANK;
            acc        <= BLANK;
            run        <= 8'd0;
            value      <= 4'h0;
            valid      <= 1'b0;
            invalid    <= 1'b0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            jump       <= 1'b0;
            step_count <= '0;
        end else begin
            s1        <= hex_in;
            s2        <= s1;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            jump      <= 1'b0;
            if (s1 != s2)
                run <= 8'd0;
            else if (run != 8'hFF)
                run <= run + 8'd1;
            if (accept) begin
                acc <= s2;
                if (glyph_ok) begin
                    value   <= glyph_val;
                    valid   <= 1'b1;
                    invalid <= 1'b0;
                    // only digit-to-digit changes are classified
                    if (valid) begin
                        if (glyph_val == val_inc) begin
                            step_up    <= 1'b1;
                            step_count <= step_count + CNT_W'(1);
                        end else if (glyph_val == val_dec) begin
                            step_down <= 1'b1;
                        end else begin
                            jump <= 1'b1;
                        end
                    end
                end else if (s2 == BLANK) begin
                    valid   <= 1'b0;
                    invalid <= 1'b0;
                end else begin
                    valid   <= 1'b0;
                    invalid <= 1'b1;
                end
            end
        end
    end

endmodule
